// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory-read, decode-handshake and core-control signals of the fetch sequencer.
// FETCH_BOUNDS_CHECK_EN adds the fetch_fault signal.
interface imem_fetch_ctrl_if;
  import imem_fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt_req;
  logic               halted;
  logic               misalign_err;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic               fetch_fault;
`endif

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
`ifdef FETCH_BOUNDS_CHECK_EN
    output fetch_fault,
`endif
    input  imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted, misalign_err,
`ifdef FETCH_BOUNDS_CHECK_EN
    input  fetch_fault,
`endif
    output imem_rdata, out_ready, redirect_valid, redirect_pc, halt_req
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue with flush and a first-word-fall-through head.
module fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && ((cnt_q < CNT_W'(DEPTH)) || pop_ok);

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the fetch queue, serves decode.
// Optional macro FETCH_BOUNDS_CHECK_EN faults and halts on fetches past MEM_WORDS.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH  = 2,
  parameter int unsigned     MEM_WORDS = 64
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0 || MEM_WORDS == 0) begin : g_bad_cfg
    $error("imem_fetch_ctrl: FQ_DEPTH must be a power of 2 >= 2 and MEM_WORDS nonzero");
  end

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             deq;
  logic             flush;
  logic             can_issue;
  logic             push;

  assign deq       = (count != '0) && bus.out_ready;
  assign flush     = bus.redirect_valid && (state_q != ST_BOOT);
  assign can_issue = (state_q == ST_RUN) && !bus.halt_req && !bus.redirect_valid &&
                     ((count < CNT_W'(FQ_DEPTH)) || deq);
  assign push_data = '{instr: bus.imem_rdata, pc: pc_q};

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q, fault_d;
  logic out_of_range;

  assign out_of_range = pc_q[PC_W-1:2] >= (PC_W-2)'(MEM_WORDS);
  assign push         = can_issue && !out_of_range;
`else
  assign push         = can_issue;
`endif

  // Next-state, PC and pulse logic; redirect overrides everything after BOOT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      ST_BOOT: state_d = bus.halt_req ? ST_HALT : ST_RUN;
      ST_RUN: begin
        if (bus.halt_req) state_d = ST_HALT;
`ifdef FETCH_BOUNDS_CHECK_EN
        else if (can_issue && out_of_range) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
`endif
      end
      ST_HALT: begin
`ifdef FETCH_BOUNDS_CHECK_EN
        if (!bus.halt_req && !fault_q) state_d = ST_RUN;
`else
        if (!bus.halt_req) state_d = ST_RUN;
`endif
      end
      default: state_d = ST_BOOT;
    endcase

    if (push) pc_d = next_pc(pc_q);

    if (flush) begin
      pc_d       = {bus.redirect_pc[PC_W-1:2], 2'b00};
      misalign_d = |bus.redirect_pc[1:0];
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_d    = 1'b0;
      if (state_q == ST_HALT && !bus.halt_req) state_d = ST_RUN;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= {RESET_PC[PC_W-1:2], 2'b00};
      misalign_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (deq),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.halted       = (state_q == ST_HALT) && (count == '0);
  assign bus.misalign_err = misalign_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bus.fetch_fault  = fault_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: cycle table plus scoreboarded fetch streams.
module tb_imem_fetch_ctrl;
  import imem_fetch_pkg::*;

  typedef struct {
    logic        rdy;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
    logic        e_halted;
    logic        e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FQ_DEPTH  (2),
    .MEM_WORDS (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]  mem [64];
  int           checks = 0;
  int           errors = 0;
  fetch_entry_t sb_q[$];
  vec_t         tbl[9];

  always_comb bus.imem_rdata = mem[bus.imem_addr[7:2]];

  function automatic logic [31:0] word(input int unsigned i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic fetch_entry_t exp_entry(input logic [31:0] pc);
    return '{instr: word(int'(pc[7:2])), pc: pc};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic chk, input logic v,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] addr);
    return '{rdy: rdy, chk_data: chk, e_valid: v, e_pc: pc, e_instr: instr,
             e_addr: addr, e_halted: 1'b0, e_mis: 1'b0};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard compare on an accepted handshake, then advance one cycle.
  task automatic step();
    fetch_entry_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready && !bus.redirect_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check32("sb_pc", bus.out_pc, e.pc);
      check32("sb_instr", bus.out_instr, e.instr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_entry(start + 32'(4 * i)));
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (sb_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    check32(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;
    @(negedge clk);
    step();
    step();

    // Back-pressure right after reset: queue saturates at two, head holds pc 0.
    tbl[0] = mk(1'b0, 1'b1, 1'b0, 32'h0,  32'h0,   32'h0);
    tbl[1] = mk(1'b0, 1'b0, 1'b0, 32'h0,  32'h0,   32'h0);
    tbl[2] = mk(1'b0, 1'b1, 1'b1, 32'h0,  word(0), 32'h4);
    tbl[3] = mk(1'b0, 1'b1, 1'b1, 32'h0,  word(0), 32'h8);
    tbl[4] = mk(1'b0, 1'b1, 1'b1, 32'h0,  word(0), 32'h8);
    tbl[5] = mk(1'b1, 1'b1, 1'b1, 32'h0,  word(0), 32'h8);
    tbl[6] = mk(1'b1, 1'b1, 1'b1, 32'h4,  word(1), 32'hC);
    tbl[7] = mk(1'b1, 1'b1, 1'b1, 32'h8,  word(2), 32'h10);
    tbl[8] = mk(1'b1, 1'b1, 1'b1, 32'hC,  word(3), 32'h14);
    reset = 1'b0;
    for (int r = 0; r < 9; r++) begin
      bus.out_ready = tbl[r].rdy;
      check32($sformatf("tbl%0d_valid", r), 32'(bus.out_valid), 32'(tbl[r].e_valid));
      check32($sformatf("tbl%0d_addr", r), bus.imem_addr, tbl[r].e_addr);
      check32($sformatf("tbl%0d_halted", r), 32'(bus.halted), 32'(tbl[r].e_halted));
      check32($sformatf("tbl%0d_mis", r), 32'(bus.misalign_err), 32'(tbl[r].e_mis));
      if (tbl[r].chk_data) begin
        check32($sformatf("tbl%0d_pc", r), bus.out_pc, tbl[r].e_pc);
        check32($sformatf("tbl%0d_instr", r), bus.out_instr, tbl[r].e_instr);
      end
      step();
    end

    // Reset mid-stream, then one instruction per cycle from pc 0 with no gaps.
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    push_stream(32'h0, 10);
    drain("stream_reset", 12);

    // Fill the queue, then redirect to 0x20: stale entries must vanish.
    bus.out_ready = 1'b0;
    step();
    step();
    check32("full_head_pc", bus.out_pc, 32'h28);
    check32("full_addr", bus.imem_addr, 32'h30);
    bus.out_ready = 1'b1;
    redirect(32'h20);
    check32("redir_valid", 32'(bus.out_valid), 32'd0);
    check32("redir_addr", bus.imem_addr, 32'h20);
    check32("redir_mis", 32'(bus.misalign_err), 32'd0);
    step();
    push_stream(32'h20, 6);
    drain("stream_redir", 8);

    // Misaligned redirect: one error pulse, fetch resumes at 0x10.
    redirect(32'h13);
    check32("mis_pulse", 32'(bus.misalign_err), 32'd1);
    check32("mis_valid", 32'(bus.out_valid), 32'd0);
    check32("mis_addr", bus.imem_addr, 32'h10);
    step();
    check32("mis_clear", 32'(bus.misalign_err), 32'd0);
    push_stream(32'h10, 4);
    drain("stream_mis", 6);

    // Halt with two queued entries: drain, freeze pc, redirect while halted, resume.
    bus.out_ready = 1'b0;
    redirect(32'h40);
    step();
    step();
    bus.halt_req  = 1'b1;
    bus.out_ready = 1'b1;
    push_stream(32'h40, 2);
    step();
    check32("halt_busy", 32'(bus.halted), 32'd0);
    step();
    check32("halt_drained", 32'(sb_q.size()), 32'd0);
    check32("halt_halted", 32'(bus.halted), 32'd1);
    check32("halt_valid", 32'(bus.out_valid), 32'd0);
    check32("halt_addr", bus.imem_addr, 32'h48);
    step();
    check32("halt_frozen", bus.imem_addr, 32'h48);
    redirect(32'h50);
    check32("halt_redir_addr", bus.imem_addr, 32'h50);
    check32("halt_redir_halted", 32'(bus.halted), 32'd1);
    step();
    check32("halt_redir_hold", bus.imem_addr, 32'h50);
    check32("halt_redir_valid", 32'(bus.out_valid), 32'd0);
    bus.halt_req = 1'b0;
    push_stream(32'h50, 3);
    drain("stream_resume", 5);

`ifdef FETCH_BOUNDS_CHECK_EN
    // Last word is delivered, the next fetch faults and halts until redirected.
    redirect(32'hFC);
    check32("bnd_fault0", 32'(bus.fetch_fault), 32'd0);
    push_stream(32'hFC, 1);
    step();
    step();
    check32("bnd_drained", 32'(sb_q.size()), 32'd0);
    check32("bnd_fault", 32'(bus.fetch_fault), 32'd1);
    check32("bnd_halted", 32'(bus.halted), 32'd1);
    check32("bnd_valid", 32'(bus.out_valid), 32'd0);
    check32("bnd_addr", bus.imem_addr, 32'h100);
    step();
    check32("bnd_latched", 32'(bus.fetch_fault), 32'd1);
    redirect(32'h0);
    check32("bnd_cleared", 32'(bus.fetch_fault), 32'd0);
    check32("bnd_unhalted", 32'(bus.halted), 32'd0);
    push_stream(32'h0, 3);
    drain("stream_bnd", 5);
`else
    // Without the bounds check, fetch runs past the last word unchanged.
    redirect(32'hFC);
    push_stream(32'hFC, 2);
    drain("stream_wrap", 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
